// File: rtl/uart_ping_pkg.sv
// Shared types and constants for the UART ping initiator.
// Holds the FSM state enum, the counter width and the expected reply offset.
package uart_ping_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RX,
    ST_GAP
  } state_t;

  localparam int         CNT_W        = 16;
  localparam logic [7:0] REPLY_OFFSET = 8'd1;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/ping_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Used for both the reply timeout and the inter-exchange gap.
module ping_timer
  import uart_ping_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - {{(W-1){1'b0}}, 1'b1};
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_ping_initiator.sv
// Ping initiator: sends seq, expects seq+1 back, tallies pass/fail/timeout.
// Define UART_PING_ERR_CAPTURE_EN to add last_err (rx_data of the latest mismatch).
module uart_ping_initiator
  import uart_ping_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int GAP_CYCLES     = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [7:0]       tx_data,
  output logic             tx_send,
  input  logic             tx_idle,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
`ifdef UART_PING_ERR_CAPTURE_EN
  output logic [7:0]       last_err,
`endif
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  // Timers count down to zero, so N cycles of residence means loading N-1.
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  state_t     state;
  logic [7:0] seq;
  logic       in_wait;
  logic       rx_hit;
  logic       to_hit;
  logic       reply_ok;
  logic       to_exp;
  logic       gap_exp;

  assign in_wait  = (state == ST_WAIT_RX);
  assign rx_hit   = in_wait && rx_valid;
  assign to_hit   = in_wait && !rx_valid && to_exp;
  assign reply_ok = (rx_data == seq + REPLY_OFFSET);

  // tx_send is decoded from the state register and the live tx_idle so it can
  // never be high in a cycle where the transmitter is not idle.
  assign tx_send = (state == ST_SEND) && tx_idle;
  assign tx_data = seq;
  assign busy    = (state != ST_IDLE);

  ping_timer #(.W(TW)) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .load     (tx_send),
    .en       (in_wait),
    .load_val (TO_LOAD),
    .expired  (to_exp)
  );

  ping_timer #(.W(TW)) u_gap (
    .clock    (clock),
    .reset    (reset),
    .load     (rx_hit || to_hit),
    .en       (state == ST_GAP),
    .load_val (GAP_LOAD),
    .expired  (gap_exp)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      seq         <= 8'h00;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (enable) state <= ST_SEND;
        ST_SEND:
          if (tx_idle) state <= ST_WAIT_RX;
        ST_WAIT_RX: begin
          // A reply landing on the expiry cycle still counts as a reply.
          if (rx_valid) begin
            if (reply_ok) pass_cnt <= sat_inc(pass_cnt);
            else          fail_cnt <= sat_inc(fail_cnt);
            seq   <= seq + 8'd1;
            state <= ST_GAP;
          end else if (to_exp) begin
            timeout_cnt <= sat_inc(timeout_cnt);
            seq         <= seq + 8'd1;
            state       <= ST_GAP;
          end
        end
        ST_GAP:
          if (gap_exp) state <= enable ? ST_SEND : ST_IDLE;
        default:
          state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_PING_ERR_CAPTURE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      last_err <= 8'h00;
    else if (rx_hit && !reply_ok)
      last_err <= rx_data;
  end
`endif

endmodule

// File: tb/tb_uart_ping_initiator.sv
// Directed bench for uart_ping_initiator with a cycle model and loopback responder.
// Works with or without UART_PING_ERR_CAPTURE_EN.
module tb_uart_ping_initiator;

  localparam int TO  = 100;
  localparam int GAP = 10;

  logic        clock = 1'b0;
  logic        reset, enable, tx_idle, rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic        tx_send, busy;
  logic [15:0] pass_cnt, fail_cnt, timeout_cnt;
  logic [7:0]  err_obs;

  always #5 clock = ~clock;

`ifdef UART_PING_ERR_CAPTURE_EN
  logic [7:0] last_err;
  assign err_obs = last_err;
`else
  assign err_obs = 8'h00;
`endif

  uart_ping_initiator #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_idle     (tx_idle),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
`ifdef UART_PING_ERR_CAPTURE_EN
    .last_err    (last_err),
`endif
    .timeout_cnt (timeout_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Responder controls and observation logs
  bit          resp_on    = 1'b0;
  int          resp_delay = 20;
  int          resp_bad   = -1;
  int          reply_at   = -1;
  logic [7:0]  reply_byte = 8'h00;
  logic [7:0]  send_log[$];
  int          send_cyc[$];
  int          to_cyc[$];
  logic [15:0] prev_to = 16'h0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: logs sends, schedules replies, timestamps timeout_cnt increments.
  initial forever begin
    @(negedge clock);
    if (tx_send === 1'b1) begin
      send_log.push_back(tx_data);
      send_cyc.push_back(cyc);
      if (resp_on) begin
        reply_at   = cyc + resp_delay;
        reply_byte = tx_data + ((int'(tx_data) == resp_bad) ? 8'd2 : 8'd1);
      end
    end
    if (timeout_cnt > prev_to) to_cyc.push_back(cyc);
    prev_to = timeout_cnt;
  end

  // Behavioural model: phase + cycles spent in phase, checked every cycle.
  initial begin : model
    int         ph, el, mp, mf, mt;
    logic [7:0] mseq, merr, want, exp_err;
    ph = 0; el = 0; mp = 0; mf = 0; mt = 0; mseq = 0; merr = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        ph = 0; el = 0; mp = 0; mf = 0; mt = 0; mseq = 0; merr = 0;
      end
`ifdef UART_PING_ERR_CAPTURE_EN
      exp_err = merr;
`else
      exp_err = 8'h00;
`endif
      chk("cycle_outputs",
          {14'h0, tx_send, busy, tx_data, pass_cnt, fail_cnt, timeout_cnt, err_obs},
          {14'h0, (ph == 1) && tx_idle, ph != 0, mseq, 16'(mp), 16'(mf), 16'(mt), exp_err});
      if (!reset) begin
        case (ph)
          0: if (enable) ph = 1;
          1: if (tx_idle) begin ph = 2; el = 0; end
          2: begin
            want = mseq + 8'd1;
            if (rx_valid) begin
              if (rx_data == want) mp = (mp < 65535) ? mp + 1 : mp;
              else begin
                mf   = (mf < 65535) ? mf + 1 : mf;
                merr = rx_data;
              end
              mseq = mseq + 8'd1; ph = 3; el = 0;
            end else if (el == TO - 1) begin
              mt   = (mt < 65535) ? mt + 1 : mt;
              mseq = mseq + 8'd1; ph = 3; el = 0;
            end else el++;
          end
          default: begin
            el++;
            if (el == GAP) ph = enable ? 1 : 0;
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    if (reply_at >= 0 && cyc == reply_at) begin
      rx_valid = 1'b1;
      rx_data  = reply_byte;
    end
  endtask

  task automatic wait_sends(input int n, input int budget, input string name);
    int k = 0;
    while (send_log.size() < n && k < budget) begin tick(); k++; end
    chk(name, 80'(send_log.size() >= n), 80'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin tick(); k++; end
    chk(name, 80'(busy), 80'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; tx_idle = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    chk("reset_busy",    80'(busy),        80'd0);
    chk("reset_tx_send", 80'(tx_send),     80'd0);
    chk("reset_tx_data", 80'(tx_data),     80'h00);
    chk("reset_pass",    80'(pass_cnt),    80'd0);
    chk("reset_fail",    80'(fail_cnt),    80'd0);
    chk("reset_timeout", 80'(timeout_cnt), 80'd0);
    reset = 1'b0;
    tick();

    // Loopback, three exchanges (reply delay shortened to fit the 100-cycle timeout)
    resp_on = 1'b1; resp_delay = 20; enable = 1'b1;
    wait_sends(3, 500, "loop_sends");
    enable = 1'b0;
    wait_idle(200, "loop_idle");
    chk("loop_tx0", 80'(send_log[0]), 80'h00);
    chk("loop_tx1", 80'(send_log[1]), 80'h01);
    chk("loop_tx2", 80'(send_log[2]), 80'h02);
    chk("loop_pass", 80'(pass_cnt), 80'd3);
    chk("loop_fail", 80'(fail_cnt), 80'd0);
    chk("loop_to",   80'(timeout_cnt), 80'd0);

    // Bad reply (byte+2) at seq 5
    resp_bad = 5; enable = 1'b1;
    wait_sends(7, 500, "bad_sends");
    enable = 1'b0;
    wait_idle(200, "bad_idle");
    resp_bad = -1;
    chk("bad_fail", 80'(fail_cnt), 80'd1);
    chk("bad_pass", 80'(pass_cnt), 80'd6);
`ifdef UART_PING_ERR_CAPTURE_EN
    chk("bad_last_err", 80'(err_obs), 80'h07);
`endif

    // No responder: two timeouts, 100 edges after each tx_send edge
    resp_on = 1'b0; enable = 1'b1;
    wait_sends(9, 600, "to_sends");
    enable = 1'b0;
    wait_idle(300, "to_idle");
    chk("to_count", 80'(timeout_cnt), 80'd2);
    chk("to_events", 80'(to_cyc.size()), 80'd2);
    if (to_cyc.size() >= 2) begin
      chk("to_delay0", 80'(to_cyc[0] - (send_cyc[7] + 1)), 80'd100);
      chk("to_delay1", 80'(to_cyc[1] - (send_cyc[8] + 1)), 80'd100);
    end
    chk("to_seq8", 80'(send_log[8]), 80'h08);

    // Reply lands exactly on the expiry cycle
    resp_on = 1'b1; resp_delay = TO; enable = 1'b1;
    wait_sends(10, 300, "race_sends");
    enable = 1'b0;
    wait_idle(300, "race_idle");
    chk("race_tx",   80'(send_log[9]), 80'h09);
    chk("race_pass", 80'(pass_cnt), 80'd7);
    chk("race_to",   80'(timeout_cnt), 80'd2);

    // Stray correct reply while IDLE
    rx_valid = 1'b1; rx_data = 8'h0B;
    tick(); tick();
    chk("stray_pass", 80'(pass_cnt), 80'd7);
    chk("stray_fail", 80'(fail_cnt), 80'd1);

    // tx_idle low for 500 cycles in SEND
    tx_idle = 1'b0; resp_delay = 5; enable = 1'b1;
    repeat (500) tick();
    chk("hold_nosend", 80'(send_log.size()), 80'd10);
    chk("hold_busy",   80'(busy), 80'd1);
    tx_idle = 1'b1;
    wait_sends(11, 20, "hold_sends");
    enable = 1'b0;
    wait_idle(100, "hold_idle");
    chk("hold_once", 80'(send_log.size()), 80'd11);
    chk("hold_tx",   80'(send_log[10]), 80'h0A);
    chk("hold_pass", 80'(pass_cnt), 80'd8);

    // Run up to seq 0xFF and across the wrap
    resp_delay = 2; enable = 1'b1;
    wait_sends(257, 8000, "wrap_sends");
    enable = 1'b0;
    wait_idle(100, "wrap_idle");
    chk("wrap_txff", 80'(send_log[255]), 80'hFF);
    chk("wrap_tx00", 80'(send_log[256]), 80'h00);
    chk("wrap_pass", 80'(pass_cnt), 80'd254);
    chk("wrap_fail", 80'(fail_cnt), 80'd1);

    // Reset in WAIT_RX, then the late reply must be ignored
    resp_delay = 50; enable = 1'b1;
    wait_sends(258, 50, "rst_sends");
    repeat (10) tick();
    reset = 1'b1; enable = 1'b0;
    #1;
    chk("rst_busy",    80'(busy),        80'd0);
    chk("rst_tx_send", 80'(tx_send),     80'd0);
    chk("rst_tx_data", 80'(tx_data),     80'h00);
    chk("rst_pass",    80'(pass_cnt),    80'd0);
    chk("rst_fail",    80'(fail_cnt),    80'd0);
    chk("rst_to",      80'(timeout_cnt), 80'd0);
    tick(); tick();
    reset = 1'b0;
    repeat (70) tick();
    chk("late_pass", 80'(pass_cnt), 80'd0);
    chk("late_fail", 80'(fail_cnt), 80'd0);
    chk("late_busy", 80'(busy),     80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_ping_initiator.md
UART_PING_INITIATOR -- requirements
Module: uart_ping_initiator

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 50000; the maximum number of cycles to wait for a reply after tx_send.
REQ-002 Parameter: GAP_CYCLES, 1000; the idle cycles inserted between exchanges.
REQ-003 Port: clock  input  1  single clock; every register is clocked on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: enable  input  1  level; while high, the block runs ping exchanges back-to-back.
REQ-006 Port: tx_data  output  8  the byte to transmit, equal to the current sequence value.
REQ-007 Port: tx_send  output  1  one-cycle pulse that requests transmission of tx_data.
REQ-008 Port: tx_idle  input  1  high when the attached UART transmitter can accept a byte.
REQ-009 Port: rx_data  input  8  the received byte.
REQ-010 Port: rx_valid  input  1  one-cycle pulse; rx_data is valid in that cycle.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: pass_cnt, fail_cnt, timeout_cnt  output  16 each  saturating exchange counters.

Function
REQ-013 FSM states: IDLE, SEND, WAIT_RX, GAP.
- IDLE -> SEND when enable=1.
REQ-014 SEND: the block SHALL hold in SEND until tx_idle=1; in that cycle it pulses tx_send=1 for exactly one cycle with tx_data=seq, then moves to WAIT_RX.
REQ-015 WAIT_RX: the timeout counter starts at 0 on entry and increments every cycle.
- rx_valid=1 -> compare rx_data against (seq+1) mod 256.
- Match -> pass_cnt+1; mismatch -> fail_cnt+1.
- The counter update is visible the cycle after rx_valid.
REQ-016 WAIT_RX timeout: when the timeout counter reaches TIMEOUT_CYCLES-1 with no rx_valid, the block SHALL increment timeout_cnt and leave WAIT_RX.
REQ-017 If rx_valid and timeout expiry occur in the same cycle, rx_valid SHALL win (pass/fail counted, timeout_cnt unchanged).
REQ-018 seq SHALL increment (8-bit wrap, 0xFF -> 0x00) on every exit from WAIT_RX.
- At seq=0xFF the expected reply is 0x00.
REQ-019 GAP: the block SHALL wait GAP_CYCLES cycles, then go to SEND if enable=1, otherwise to IDLE.
REQ-020 Deasserting enable outside IDLE SHALL NOT abort the exchange in progress; the block stops after that exchange's GAP.
REQ-021 rx_valid outside WAIT_RX SHALL be ignored (no counter changes).
REQ-022 All three counters SHALL saturate at 0xFFFF.
REQ-023 tx_send SHALL never be asserted while tx_idle=0.

Reset
REQ-024 Reset SHALL immediately force these values:
- state=IDLE, seq=0x00
- tx_send=0, tx_data=0x00, busy=0
- all counters 0
- timeout and gap timers 0
- last_err (when present) 0x00.
REQ-025 Reset mid-exchange SHALL abandon the exchange with no counter update; a reply arriving after reset deassertion falls under REQ-021.

Configuration
REQ-026 Macro UART_PING_ERR_CAPTURE_EN: when defined, an extra output last_err (8-bit) SHALL hold rx_data of the most recent mismatch.
- It updates the same cycle fail_cnt increments.
- Without the macro, the port and its register SHALL NOT exist and behaviour is otherwise identical.

Structure
REQ-027 A shared package uart_ping_pkg SHALL hold:
- the FSM state enum
- the counter width constant (16)
- the reply-offset constant (1).
REQ-028 A sub-module ping_timer (loadable down-counter with an expiry flag) SHALL implement both the timeout and gap timers as two instances.

Verification
REQ-029 Loopback responder returning byte+1 after 200 cycles, enable=1 for 3 exchanges -> tx_data 0x00, 0x01, 0x02; pass_cnt=3, fail_cnt=0, timeout_cnt=0.
REQ-030 Responder returns byte+2 once at seq=0x05 -> fail_cnt=1; last_err=0x07 when the macro is defined.
REQ-031 No responder, TIMEOUT_CYCLES=100 -> timeout_cnt increments exactly 100 cycles after each tx_send; seq still advances.
REQ-032 rx_valid with the correct reply in the exact cycle of timeout expiry -> pass_cnt+1, timeout_cnt unchanged.
REQ-033 Preload seq=0xFF via 255 exchanges, responder replies 0x00 -> pass; next tx_data=0x00.
REQ-034 tx_idle held 0 for 500 cycles in SEND, then asserted -> tx_send pulses once after tx_idle rises. Reset asserted in WAIT_RX -> all outputs zero at once and the later reply is ignored.
